// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_fifo
//  Description : Scans the debounced key vector one key per cycle and queues
//                press/release events in a show-ahead FIFO for the SPI side.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_fifo #(
   parameter int NUM_KEYS = 61,
   parameter int DEPTH    = 16
) (
   input  logic                     clk_g_i,
   input  logic                     rstn_g_i,
   input  logic [NUM_KEYS-1:0]      keys_i,
   input  logic                     pop_i,
   input  logic                     overflow_clr_i,
   output logic [7:0]               event_o,
   output logic                     event_valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_KEYS - 1);
   localparam logic [PTR_W:0]   c_depth    = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   c_one      = (PTR_W + 1)'(1);

   logic [NUM_KEYS-1:0] r_prev;
   logic [IDX_W-1:0]    r_idx;
   logic [7:0]          r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W:0]      r_count;
   logic [7:0]          r_head;
   logic                r_overflow;

   logic                w_key;
   logic                w_change;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic [6:0]          w_idx7;
   logic [7:0]          w_data;
   logic [PTR_W-1:0]    w_rd_next;
   logic [7:0]          w_head_nxt;

   // Full is judged on the registered count, so a same-cycle pop never frees
   // room for the push that is being evaluated.
   assign w_key     = keys_i[r_idx];
   assign w_change  = (w_key != r_prev[r_idx]);
   assign w_full    = (r_count == c_depth);
   assign w_empty   = (r_count == '0);
   assign w_push    = w_change & ~w_full;
   assign w_pop     = pop_i & ~w_empty;
   assign w_idx7    = 7'(r_idx);
   assign w_data    = {w_key, w_idx7};
   assign w_rd_next = r_rd_ptr + 1'b1;

   // Head register keeps event_o free of read latency: it loads the entry
   // behind the popped one, or the incoming event when the queue drains to it.
   always_comb begin
      w_head_nxt = r_head;
      if (w_pop) begin
         if (r_count > c_one) begin
            w_head_nxt = r_mem[w_rd_next];
         end else if (w_push) begin
            w_head_nxt = w_data;
         end
      end else if (w_empty && w_push) begin
         w_head_nxt = w_data;
      end
   end

   // Event storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk_g_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_data;
      end
   end

   // Scanner, last-reported key state and overflow flag.
   always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
      if (!rstn_g_i) begin
         r_prev     <= '0;
         r_idx      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
         if (w_push) begin
            r_prev[r_idx] <= w_key;
         end
         // A blocked change wins over a same-cycle clear.
         if (w_change && w_full) begin
            r_overflow <= 1'b1;
         end else if (overflow_clr_i) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // FIFO pointers, occupancy count and head register.
   always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
      if (!rstn_g_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= 8'h00;
      end else begin
         r_head <= w_head_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign event_o       = r_head;
   assign event_valid_o = ~w_empty;
   assign count_o       = r_count;
   assign overflow_o    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_fifo
//  Description : Self-checking scoreboard bench for key_event_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_fifo;

   localparam int NUM_KEYS = 61;
   localparam int DEPTH    = 16;

   logic                    clk = 1'b0;
   logic                    rstn = 1'b0;
   logic [NUM_KEYS-1:0]     keys = '0;
   logic                    pop = 1'b0;
   logic                    clr = 1'b0;
   logic [7:0]              ev;
   logic                    ev_valid;
   logic [$clog2(DEPTH):0]  cnt;
   logic                    ovf;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q [$];

   key_event_fifo #(.NUM_KEYS(NUM_KEYS), .DEPTH(DEPTH)) u_dut (
      .clk_g_i        (clk),
      .rstn_g_i       (rstn),
      .keys_i         (keys),
      .pop_i          (pop),
      .overflow_clr_i (clr),
      .event_o        (ev),
      .event_valid_o  (ev_valid),
      .count_o        (cnt),
      .overflow_o     (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && ev_valid !== 1'b1; i++) @(negedge clk);
      chk("event_arrives", 32'(ev_valid), 1);
   endtask

   // Consume the head event and compare it with the scoreboard.
   task automatic pop_one(input bit any_order, input int budget);
      int hit;
      wait_valid(budget);
      if (ev_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", exp_q.size(), 1);
         end else if (!any_order) begin
            chk("event", ev, exp_q.pop_front());
         end else begin
            hit = -1;
            foreach (exp_q[i]) if (hit < 0 && exp_q[i] == ev) hit = i;
            chk("event_in_set", 32'(hit >= 0), 1);
            if (hit >= 0) exp_q.delete(hit);
         end
         pop = 1'b1;
         @(negedge clk);
         pop = 1'b0;
      end
   endtask

   task automatic expect_quiet(input int cycles, input string tag);
      bit seen;
      seen = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         if (ev_valid !== 1'b0) seen = 1'b1;
      end
      chk(tag, 32'(seen), 0);
   endtask

   task automatic do_reset(input logic [NUM_KEYS-1:0] k);
      @(negedge clk);
      rstn = 1'b0;
      keys = k;
      pop  = 1'b0;
      clr  = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      logic [NUM_KEYS-1:0] mask;

      // Reset state and idle behaviour
      @(negedge clk);
      chk("rst_count", 32'(cnt), 0);
      chk("rst_valid", 32'(ev_valid), 0);
      chk("rst_event", 32'(ev), 0);
      chk("rst_ovf", 32'(ovf), 0);
      rstn = 1'b1;
      expect_quiet(3 * NUM_KEYS, "idle_no_events");
      chk("idle_count", 32'(cnt), 0);
      chk("idle_ovf", 32'(ovf), 0);

      // Single key press then release
      repeat (10) @(negedge clk);
      keys[5] = 1'b1;
      exp_q.push_back(8'h85);
      pop_one(1'b0, 62);
      chk("press_count0", 32'(cnt), 0);
      expect_quiet(2 * NUM_KEYS, "press_no_dup");
      keys[5] = 1'b0;
      exp_q.push_back(8'h05);
      pop_one(1'b0, 62);
      chk("release_count0", 32'(cnt), 0);
      expect_quiet(2 * NUM_KEYS, "release_no_dup");

      // Keys held through reset appear in index order
      mask = '0;
      mask[0] = 1'b1; mask[30] = 1'b1; mask[60] = 1'b1;
      do_reset(mask);
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h9E);
      exp_q.push_back(8'hBC);
      repeat (NUM_KEYS + 2) @(negedge clk);
      chk("held_count3", 32'(cnt), 3);
      repeat (3) pop_one(1'b0, 8);
      chk("held_count0", 32'(cnt), 0);

      // Overflow: 20 presses into a 16-deep FIFO
      mask = '0;
      for (int i = 0; i < 20; i++) mask[3 * i] = 1'b1;
      do_reset(mask);
      repeat (2 * NUM_KEYS) @(negedge clk);
      chk("full_count", 32'(cnt), DEPTH);
      chk("full_ovf", 32'(ovf), 1);
      for (int i = 0; i < 16; i++) exp_q.push_back(8'h80 | 8'(3 * i));
      repeat (16) pop_one(1'b0, 8);
      chk("ovf_sticky", 32'(ovf), 1);
      for (int i = 16; i < 20; i++) exp_q.push_back(8'h80 | 8'(3 * i));
      repeat (4) pop_one(1'b1, 4 * NUM_KEYS);
      chk("ovf_all_seen", exp_q.size(), 0);
      expect_quiet(2 * NUM_KEYS, "ovf_no_dup");
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("ovf_cleared", 32'(ovf), 0);

      // Continuous pop while one push arrives every cycle
      mask = '0;
      for (int i = 0; i <= 10; i++) mask[i] = 1'b1;
      do_reset(mask);
      for (int i = 0; i <= 10; i++) exp_q.push_back(8'h80 | 8'(i));
      repeat (20) begin
         @(negedge clk);
         chk("stream_count_le2", 32'(cnt <= 2), 1);
         if (ev_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("stream_unexpected", exp_q.size(), 1);
            else chk("stream_event", ev, exp_q.pop_front());
            pop = 1'b1;
         end else begin
            pop = 1'b0;
         end
      end
      pop = 1'b0;
      chk("stream_all_seen", exp_q.size(), 0);
      chk("stream_count0", 32'(cnt), 0);
      chk("stream_no_ovf", 32'(ovf), 0);

      // Asynchronous reset with queued events
      mask = '0;
      for (int i = 0; i < 7; i++) mask[i] = 1'b1;
      do_reset(mask);
      repeat (10) @(negedge clk);
      chk("pre_reset_count7", 32'(cnt), 7);
      #2 rstn = 1'b0;
      #1;
      chk("async_count", 32'(cnt), 0);
      chk("async_valid", 32'(ev_valid), 0);
      chk("async_event", 32'(ev), 0);
      chk("async_ovf", 32'(ovf), 0);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h80 | 8'(i));
      repeat (7) pop_one(1'b0, 2 * NUM_KEYS);
      chk("post_reset_count0", 32'(cnt), 0);
      chk("post_reset_all_seen", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
